ntt_addr_dispatch_k2: RTL and testbench
=======================================

Name: ntt_addr_dispatch_k2

Overview:
- Sits directly downstream of the k2-stage address generator.
- Captures each 16-index beat (8 consecutive j values × {Order_0, Order_1}) and buffers it in a small FIFO.
- Maps every index to a conflict-free memory bank and in-bank address.
- Issues one mapped beat per cycle to the butterfly memory read port under a valid/ready handshake, and signals end-of-stage once all beats have drained.

Parameters:
- D_WIDTH, 10: index width; matches `D_width.
- LANES, 16: indices per beat, fixed at 2×8.
- BANK_BITS, 4: log2 of bank count; 16 banks.
- FIFO_DEPTH, 4: beat entries; must be a power of two.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  AGU_out_en_k2; held high for the whole stage
- in_done  in  1  AGU_done_k2; one-cycle pulse
- in_order  in  LANES*D_WIDTH  lane 2i = Order_0_k2_add i; lane 2i+1 = Order_1_k2_add i (lane 0 at LSB)
- out_valid  out  1  mapped beat available
- out_ready  in  1  memory port accepts the beat
- out_bank  out  LANES*BANK_BITS  per-lane bank select
- out_addr  out  LANES*(D_WIDTH-BANK_BITS)  per-lane in-bank address
- dispatch_done  out  1  one-cycle pulse once the stage is fully drained
- conflict_err  out  1  sticky: two lanes of one beat mapped to the same bank
- overflow_err  out  1  sticky: a beat was captured while the FIFO was full

Behaviour:
- Reset (rst==0 at posedge):
  - All outputs 0, FIFO empty, phase=0, FSM=IDLE.
  - Applies mid-operation: pending beats are discarded.
- Capture phase:
  - phase toggles every cycle while in_valid=1 and is forced to 0 when in_valid=0.
  - A beat is captured only on cycles where in_valid=1, phase=1 and FSM=RUN. The upstream holds each j for 2 cycles; this samples the second, stable cycle.
- FSM transitions:
  - IDLE: in_valid=1 -> RUN. The first cycle has phase=0, so there is no capture.
  - RUN:
    - Captures beats.
    - in_done=1 -> DRAIN. A capture coinciding with in_done is discarded (the upstream j has already wrapped).
    - in_valid falling without in_done -> DRAIN.
  - DRAIN: no capture; when FIFO empty and no out_valid pending -> DONE.
  - DONE: dispatch_done=1 for exactly one cycle -> IDLE. IDLE is re-entered only after in_valid has been seen low.
- FIFO:
  - Write on capture; read when the output register is empty or (out_valid && out_ready).
  - Simultaneous read and write at full is allowed: the write succeeds and the count is unchanged.
  - Write at full with no read: the beat is dropped, overflow_err is set, and the FIFO contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Mapping, combinational on the FIFO head, registered into the output stage:
  - Zero-extend the index to a multiple of BANK_BITS.
  - bank = XOR of all 4-bit digits.
  - addr = idx[D_WIDTH-1:BANK_BITS].
  - Example: idx 0x3FF -> bank F^F^3=0x3, addr 0x3F.
- Output stage:
  - out_valid/out_bank/out_addr are registered and stay stable while out_valid && !out_ready.
  - Latency: a beat captured at edge E with an empty pipeline gives out_valid=1 after edge E+1.
  - Throughput is 1 beat/cycle; sustained upstream rate is 1 beat per 2 cycles.
- conflict_err:
  - Computed on the beat loaded into the output register; set when any pair of its 16 banks is equal.
  - Sticky until reset; the beat is still issued.
- Errors never block dispatch_done.

Test Plan:
- Reset, then hold in_valid=1 for 4 cycles with out_ready=1 -> captures occur on cycles 2 and 4 only; out_valid first high 1 cycle after the first capture; all error flags stay 0.
- Lane 0 idx 0x013, lane 1 idx 0x3FF -> out_bank lane0=0x2, lane1=0x3; out_addr lane0=0x01, lane1=0x3F.
- Full stage of 128 j values (16 beats), out_ready=1, in_done pulsed after the last beat -> exactly 16 out handshakes, then dispatch_done high for 1 cycle; FSM returns to IDLE.
- out_ready=0 for 12 cycles during RUN -> FIFO fills after 4 captures, the 5th capture sets overflow_err; out_bank/out_addr stay stable while stalled; on release, exactly 5 beats issue (4 FIFO + 1 in the output register).
- Beat with lanes 0 and 1 = 0x000 and 0x011 (both bank 0) -> conflict_err=1, beat still issued; conflict_err stays 1 until reset.
- rst=0 for one cycle mid-RUN with 2 beats buffered -> next cycle out_valid=0, FIFO empty, no dispatch_done; a new stage then runs normally.

Source files
------------

// File: rtl/ntt_addr_dispatch_k2_if.sv
// Bus between the k2 address generator, the dispatcher and the butterfly memory read port.
// Output handshake: a beat transfers on a rising clk edge where out_valid && out_ready; the producer holds out_bank/out_addr stable while out_valid && !out_ready.
interface ntt_addr_dispatch_k2_if #(
  parameter int D_WIDTH   = 10,
  parameter int LANES     = 16,
  parameter int BANK_BITS = 4
);
  logic                                 in_valid;
  logic                                 in_done;
  logic [LANES*D_WIDTH-1:0]             in_order;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [LANES*BANK_BITS-1:0]           out_bank;
  logic [LANES*(D_WIDTH-BANK_BITS)-1:0] out_addr;
  logic                                 dispatch_done;
  logic                                 conflict_err;
  logic                                 overflow_err;

  modport master (
    output in_valid, in_done, in_order, out_ready,
    input  out_valid, out_bank, out_addr, dispatch_done, conflict_err, overflow_err
  );

  modport slave (
    input  in_valid, in_done, in_order, out_ready,
    output out_valid, out_bank, out_addr, dispatch_done, conflict_err, overflow_err
  );
endinterface

// File: rtl/ntt_addr_dispatch_k2.sv
// Captures k2-stage index beats into a small FIFO, maps each index to bank/in-bank address
// and issues one mapped beat per cycle to the butterfly memory read port.
module ntt_addr_dispatch_k2 #(
  parameter int D_WIDTH    = 10,
  parameter int LANES      = 16,
  parameter int BANK_BITS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ntt_addr_dispatch_k2_if.slave bus,
  output logic [2:0]            dbg_state
);
  localparam int ADDR_W = D_WIDTH - BANK_BITS;
  localparam int BEAT_W = LANES * D_WIDTH;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int NDIG   = (D_WIDTH + BANK_BITS - 1) / BANK_BITS;
  localparam int PAD_W  = NDIG * BANK_BITS;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_WAIT_LOW} state_t;

  state_t                     state_q, state_d;
  logic                       phase_q, phase_d;
  logic [BEAT_W-1:0]          mem_q [FIFO_DEPTH];
  logic [BEAT_W-1:0]          mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]             count_q, count_d;
  logic                       out_valid_q, out_valid_d;
  logic [LANES*BANK_BITS-1:0] out_bank_q, out_bank_d;
  logic [LANES*ADDR_W-1:0]    out_addr_q, out_addr_d;
  logic                       conflict_q, conflict_d;
  logic                       overflow_q, overflow_d;

  logic                       capture, full, rd_en, wr_en, hit;
  logic [BEAT_W-1:0]          head;
  logic [LANES*BANK_BITS-1:0] map_bank;
  logic [LANES*ADDR_W-1:0]    map_addr;
  logic [PAD_W-1:0]           idx_pad;
  logic [BANK_BITS-1:0]       bank_acc;

  // Bank is the XOR of all BANK_BITS-wide digits of the zero-extended index.
  always_comb begin
    head     = mem_q[rd_ptr_q];
    map_bank = '0;
    map_addr = '0;
    idx_pad  = '0;
    bank_acc = '0;
    hit      = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      idx_pad  = PAD_W'(head[l*D_WIDTH +: D_WIDTH]);
      bank_acc = '0;
      for (int d = 0; d < NDIG; d++) begin
        bank_acc = bank_acc ^ idx_pad[d*BANK_BITS +: BANK_BITS];
      end
      map_bank[l*BANK_BITS +: BANK_BITS] = bank_acc;
      map_addr[l*ADDR_W +: ADDR_W]       = head[l*D_WIDTH+BANK_BITS +: ADDR_W];
    end
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (map_bank[i*BANK_BITS +: BANK_BITS] == map_bank[j*BANK_BITS +: BANK_BITS]) hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = bus.in_valid ? ~phase_q : 1'b0;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_bank_d  = out_bank_q;
    out_addr_d  = out_addr_q;
    conflict_d  = conflict_q;
    overflow_d  = overflow_q;

    // Upstream holds each j for two cycles; sample the second one. A beat alongside in_done is stale.
    capture = bus.in_valid && phase_q && (state_q == S_RUN) && !bus.in_done;
    full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    rd_en   = (count_q != '0) && (!out_valid_q || bus.out_ready);
    wr_en   = capture && (!full || rd_en);

    if (wr_en) begin
      mem_d[wr_ptr_q] = bus.in_order;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (capture && full && !rd_en) overflow_d = 1'b1;
    count_d = count_q + (PTR_W+1)'(wr_en) - (PTR_W+1)'(rd_en);

    if (rd_en) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      out_valid_d = 1'b1;
      out_bank_d  = map_bank;
      out_addr_d  = map_addr;
      if (hit) conflict_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE:     if (bus.in_valid) state_d = S_RUN;
      S_RUN:      if (bus.in_done || !bus.in_valid) state_d = S_DRAIN;
      S_DRAIN:    if ((count_q == '0) && !out_valid_q) state_d = S_DONE;
      S_DONE:     state_d = bus.in_valid ? S_WAIT_LOW : S_IDLE;
      S_WAIT_LOW: if (!bus.in_valid) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_bank_q  <= '0;
      out_addr_q  <= '0;
      conflict_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_bank_q  <= out_bank_d;
      out_addr_q  <= out_addr_d;
      conflict_q  <= conflict_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only read once count_q says they were written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_bank      = out_bank_q;
  assign bus.out_addr      = out_addr_q;
  assign bus.dispatch_done = (state_q == S_DONE);
  assign bus.conflict_err  = conflict_q;
  assign bus.overflow_err  = overflow_q;
  assign dbg_state         = state_q;
endmodule

// File: tb/tb_ntt_addr_dispatch_k2.sv
// Self-checking bench for ntt_addr_dispatch_k2: per-feature tasks plus an output scoreboard.
module tb_ntt_addr_dispatch_k2;
  localparam int D_WIDTH   = 10;
  localparam int LANES     = 16;
  localparam int BANK_BITS = 4;
  localparam int ADDR_W    = D_WIDTH - BANK_BITS;
  localparam int BEAT_W    = LANES * D_WIDTH;
  localparam int EXP_W     = LANES * (BANK_BITS + ADDR_W);
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  ntt_addr_dispatch_k2_if #(.D_WIDTH(D_WIDTH), .LANES(LANES), .BANK_BITS(BANK_BITS)) bus ();

  ntt_addr_dispatch_k2 #(.D_WIDTH(D_WIDTH), .LANES(LANES), .BANK_BITS(BANK_BITS), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int hs_count = 0;
  int done_count = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EXP_W-1:0] exp_of(input logic [BEAT_W-1:0] beat);
    logic [LANES*BANK_BITS-1:0] bk;
    logic [LANES*ADDR_W-1:0]    ad;
    logic [9:0]                 idx;
    for (int l = 0; l < LANES; l++) begin
      idx = beat[l*10 +: 10];
      bk[l*4 +: 4] = idx[3:0] ^ idx[7:4] ^ {2'b00, idx[9:8]};
      ad[l*6 +: 6] = idx[9:4];
    end
    return {ad, bk};
  endfunction

  // Every lane shares the upper digits, low digit is lane ^ r: all 16 banks distinct.
  function automatic logic [BEAT_W-1:0] rand_beat();
    logic [BEAT_W-1:0] b;
    logic [1:0] hi;
    logic [3:0] mid, r, lo;
    hi  = 2'($urandom_range(0, 3));
    mid = 4'($urandom_range(0, 15));
    r   = 4'($urandom_range(0, 15));
    for (int l = 0; l < LANES; l++) begin
      lo = 4'(l) ^ r;
      b[l*10 +: 10] = {hi, mid, lo};
    end
    return b;
  endfunction

  // driver tasks
  task automatic present(input logic [BEAT_W-1:0] b, input bit push);
    bus.in_order = b;
    if (push) exp_q.push_back(exp_of(b));
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_done   = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_order  = '0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
  endtask

  task automatic wait_done(input int budget);
    int start;
    bit seen;
    start = done_count;
    seen  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_count != start) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      $display("FAIL wait_done: no dispatch_done within %0d cycles", budget);
      bad++;
    end
  endtask

  task automatic run_stage(input int n);
    bus.in_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      present(rand_beat(), 1'b1);
      tick();
      tick();
    end
    bus.in_done = 1'b1;
    tick();
    bus.in_done  = 1'b0;
    bus.in_valid = 1'b0;
    wait_done(80);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (bus.dispatch_done) done_count++;
      if (bus.out_valid && bus.out_ready) begin
        logic [EXP_W-1:0] e;
        hs_count++;
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL scoreboard: unexpected beat got addr=%h bank=%h required none", bus.out_addr, bus.out_bank);
          bad++;
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_addr, bus.out_bank} !== e) begin
            $display("FAIL scoreboard: got %h required %h", {bus.out_addr, bus.out_bank}, e);
            bad++;
          end
        end
      end
    end
  end

  task automatic test_reset();
    bus.in_valid  = 1'b1;
    bus.in_done   = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    total++; if (bus.out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); bad++; end
    total++; if (bus.dispatch_done !== 1'b0) begin $display("FAIL reset_done: got %b required 0", bus.dispatch_done); bad++; end
    total++; if (bus.conflict_err !== 1'b0) begin $display("FAIL reset_conflict: got %b required 0", bus.conflict_err); bad++; end
    total++; if (bus.overflow_err !== 1'b0) begin $display("FAIL reset_overflow: got %b required 0", bus.overflow_err); bad++; end
    total++; if (dbg_state !== ST_IDLE) begin $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE); bad++; end
    do_reset();
  endtask

  task automatic test_capture_timing();
    logic [BEAT_W-1:0] b0;
    logic [4:0] ov;
    logic [4:0] ov_exp;
    int hs0;
    ov_exp = 5'b10100;
    do_reset();
    hs0 = hs_count;
    b0[9:0]   = 10'h013;
    b0[19:10] = 10'h3FF;
    b0[29:20] = 10'h000;
    b0[39:30] = 10'h001;
    for (int l = 4; l < LANES; l++) b0[l*10 +: 10] = 10'(l);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    present(b0, 1'b1);
    for (int e = 1; e <= 5; e++) begin
      if (e == 3) present(rand_beat(), 1'b1);
      if (e == 5) bus.in_valid = 1'b0;
      tick();
      ov[e-1] = bus.out_valid;
      if (e == 3) begin
        total++; if (bus.out_bank[3:0] !== 4'h2) begin $display("FAIL map_bank0: got %h required 2", bus.out_bank[3:0]); bad++; end
        total++; if (bus.out_bank[7:4] !== 4'h3) begin $display("FAIL map_bank1: got %h required 3", bus.out_bank[7:4]); bad++; end
        total++; if (bus.out_addr[5:0] !== 6'h01) begin $display("FAIL map_addr0: got %h required 01", bus.out_addr[5:0]); bad++; end
        total++; if (bus.out_addr[11:6] !== 6'h3F) begin $display("FAIL map_addr1: got %h required 3f", bus.out_addr[11:6]); bad++; end
      end
    end
    total++; if (ov !== ov_exp) begin $display("FAIL capture_timing: out_valid after edges 5..1 got %b required %b", ov, ov_exp); bad++; end
    wait_done(20);
    total++; if (hs_count - hs0 != 2) begin $display("FAIL capture_count: got %0d required 2", hs_count - hs0); bad++; end
    total++; if ({bus.conflict_err, bus.overflow_err} !== 2'b00) begin $display("FAIL capture_errs: got %b required 00", {bus.conflict_err, bus.overflow_err}); bad++; end
  endtask

  task automatic test_full_stage();
    int hs0, d0;
    do_reset();
    hs0 = hs_count;
    d0  = done_count;
    bus.out_ready = 1'b1;
    run_stage(16);
    tick();
    tick();
    tick();
    total++; if (hs_count - hs0 != 16) begin $display("FAIL full_handshakes: got %0d required 16", hs_count - hs0); bad++; end
    total++; if (done_count - d0 != 1) begin $display("FAIL full_done_width: got %0d required 1", done_count - d0); bad++; end
    total++; if (dbg_state !== ST_IDLE) begin $display("FAIL full_state: got %0d required %0d", dbg_state, ST_IDLE); bad++; end
    total++; if (exp_q.size() != 0) begin $display("FAIL full_leftover: got %0d required 0", exp_q.size()); bad++; end
    total++; if ({bus.conflict_err, bus.overflow_err} !== 2'b00) begin $display("FAIL full_errs: got %b required 00", {bus.conflict_err, bus.overflow_err}); bad++; end
  endtask

  task automatic test_overflow();
    logic [LANES*BANK_BITS-1:0] snap_bank;
    logic [LANES*ADDR_W-1:0]    snap_addr;
    int hs0;
    do_reset();
    hs0 = hs_count;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    present(rand_beat(), 1'b1);
    tick();
    tick();
    bus.out_ready = 1'b0;
    present(rand_beat(), 1'b1);
    tick();
    snap_bank = bus.out_bank;
    snap_addr = bus.out_addr;
    total++; if (bus.out_valid !== 1'b1) begin $display("FAIL ovf_first_valid: got %b required 1", bus.out_valid); bad++; end
    tick();
    for (int k = 2; k <= 4; k++) begin
      present(rand_beat(), 1'b1);
      tick();
      tick();
    end
    total++; if (bus.overflow_err !== 1'b0) begin $display("FAIL ovf_early: got %b required 0", bus.overflow_err); bad++; end
    present(rand_beat(), 1'b0);
    tick();
    tick();
    total++; if (bus.overflow_err !== 1'b1) begin $display("FAIL ovf_set: got %b required 1", bus.overflow_err); bad++; end
    bus.in_valid = 1'b0;
    tick();
    tick();
    total++; if ({bus.out_bank, bus.out_addr} !== {snap_bank, snap_addr}) begin $display("FAIL ovf_stable: got %h required %h", {bus.out_bank, bus.out_addr}, {snap_bank, snap_addr}); bad++; end
    total++; if (hs_count != hs0) begin $display("FAIL ovf_stall: got %0d handshakes required 0", hs_count - hs0); bad++; end
    bus.out_ready = 1'b1;
    wait_done(30);
    total++; if (hs_count - hs0 != 5) begin $display("FAIL ovf_release: got %0d required 5", hs_count - hs0); bad++; end
    total++; if (bus.overflow_err !== 1'b1) begin $display("FAIL ovf_sticky: got %b required 1", bus.overflow_err); bad++; end
  endtask

  task automatic test_conflict();
    logic [BEAT_W-1:0] b;
    int hs0;
    do_reset();
    hs0 = hs_count;
    b[9:0]   = 10'h000;
    b[19:10] = 10'h011;
    for (int l = 2; l < LANES; l++) b[l*10 +: 10] = 10'(l);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    present(b, 1'b1);
    tick();
    tick();
    total++; if (bus.conflict_err !== 1'b0) begin $display("FAIL conflict_early: got %b required 0", bus.conflict_err); bad++; end
    bus.in_valid = 1'b0;
    tick();
    total++; if (bus.conflict_err !== 1'b1) begin $display("FAIL conflict_set: got %b required 1", bus.conflict_err); bad++; end
    wait_done(20);
    total++; if (hs_count - hs0 != 1) begin $display("FAIL conflict_issued: got %0d required 1", hs_count - hs0); bad++; end
    run_stage(2);
    total++; if (bus.conflict_err !== 1'b1) begin $display("FAIL conflict_sticky: got %b required 1", bus.conflict_err); bad++; end
    do_reset();
    total++; if (bus.conflict_err !== 1'b0) begin $display("FAIL conflict_cleared: got %b required 0", bus.conflict_err); bad++; end
  endtask

  task automatic test_reset_mid_run();
    int hs0, d0;
    bit stray;
    do_reset();
    bus.in_valid = 1'b1;
    present(rand_beat(), 1'b1);
    tick();
    tick();
    present(rand_beat(), 1'b1);
    tick();
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    exp_q.delete();
    total++; if (bus.out_valid !== 1'b0) begin $display("FAIL midrst_valid: got %b required 0", bus.out_valid); bad++; end
    total++; if (dbg_state !== ST_IDLE) begin $display("FAIL midrst_state: got %0d required %0d", dbg_state, ST_IDLE); bad++; end
    bus.out_ready = 1'b1;
    hs0 = hs_count;
    d0  = done_count;
    stray = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_valid !== 1'b0 || bus.dispatch_done !== 1'b0) stray = 1'b1;
    end
    total++; if (stray) begin $display("FAIL midrst_quiet: got activity after reset required none"); bad++; end
    run_stage(3);
    tick();
    total++; if (hs_count - hs0 != 3) begin $display("FAIL midrst_restart: got %0d required 3", hs_count - hs0); bad++; end
    total++; if (done_count - d0 != 1) begin $display("FAIL midrst_done: got %0d required 1", done_count - d0); bad++; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_done   = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_order  = '0;
    test_reset();
    test_capture_timing();
    test_full_stage();
    test_overflow();
    test_conflict();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
